// File: rtl/cl_dmem_sequencer.sv
// Data-memory sequencer for the execute stage: one valid/yumi request per mem op, stalls until done.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN.
module cl_dmem_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  op_valid_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic                  is_byte_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  stall_o,
  output logic                  load_valid_o,
  output logic [31:0]           load_data_o,
  output logic                  misalign_o,
  output logic                  timeout_o,
  output logic                  dmem_req_valid_o,
  output logic                  dmem_req_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr_o,
  output logic [31:0]           dmem_req_wdata_o,
  output logic [3:0]            dmem_req_mask_o,
  input  logic                  dmem_req_yumi_i,
  input  logic                  dmem_rsp_valid_i,
  input  logic [31:0]           dmem_rsp_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic                  r_is_load, r_we, r_misalign;
  logic                  r_is_byte;
  logic [1:0]            r_lane;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [31:0]           r_wdata, r_load_data;
  logic [3:0]            r_mask;

  logic                  w_mem_op, w_misaligned, w_capture, w_timeout_hit;
  logic [3:0]            w_mask_in;
  logic [31:0]           w_wdata_in, w_rsp_fmt;
  logic [7:0]            w_rsp_byte;

  assign w_mem_op     = op_valid_i & (is_load_i | is_store_i);
  assign w_misaligned = ~is_byte_i & (addr_i[1:0] != 2'b00);
  assign w_capture    = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  assign w_mask_in    = is_byte_i ? (4'b0001 << addr_i[1:0]) : 4'hF;
  assign w_wdata_in   = is_byte_i ? {4{store_data_i[7:0]}} : store_data_i;

  // Little-endian lane pick for LBU; the lane comes from the captured address.
  always_comb begin
    w_rsp_byte = dmem_rsp_data_i[7:0];
    case (r_lane)
      2'd0: w_rsp_byte = dmem_rsp_data_i[7:0];
      2'd1: w_rsp_byte = dmem_rsp_data_i[15:8];
      2'd2: w_rsp_byte = dmem_rsp_data_i[23:16];
      2'd3: w_rsp_byte = dmem_rsp_data_i[31:24];
      default: w_rsp_byte = dmem_rsp_data_i[7:0];
    endcase
  end
  assign w_rsp_fmt = r_is_byte ? {24'b0, w_rsp_byte} : dmem_rsp_data_i;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  // A completing handshake in the limit cycle wins over the watchdog.
  assign w_timeout_hit = ((r_state == S_REQ && !dmem_req_yumi_i) ||
                          (r_state == S_WAIT_RSP && !dmem_rsp_valid_i)) && (r_cnt == C_LIMIT);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_capture) r_cnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT_RSP) r_cnt <= r_cnt + 1'b1;
      r_timeout <= r_timeout | w_timeout_hit;
    end
  end
  assign timeout_o = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = (TIMEOUT_CYCLES > 0);
  assign w_timeout_hit = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    stall_o          = 1'b0;
    dmem_req_valid_o = 1'b0;
    load_valid_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          stall_o      = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        stall_o          = 1'b1;
        dmem_req_valid_o = 1'b1;
        if (dmem_req_yumi_i)    w_state_next = r_we ? S_DONE : S_WAIT_RSP;
        else if (w_timeout_hit) w_state_next = S_DONE;
      end
      S_WAIT_RSP: begin
        stall_o = 1'b1;
        if (dmem_rsp_valid_i || w_timeout_hit) w_state_next = S_DONE;
      end
      S_DONE: begin
        load_valid_o = r_is_load;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_is_load   <= 1'b0;
      r_we        <= 1'b0;
      r_is_byte   <= 1'b0;
      r_lane      <= 2'b00;
      r_req_addr  <= '0;
      r_wdata     <= 32'h0;
      r_mask      <= 4'h0;
      r_load_data <= 32'h0;
      r_misalign  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_misalign <= (r_state == S_IDLE) & w_mem_op & w_misaligned;
      if (w_capture) begin
        r_is_load  <= is_load_i;
        r_we       <= is_store_i & ~is_load_i;
        r_is_byte  <= is_byte_i;
        r_lane     <= addr_i[1:0];
        r_req_addr <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        r_wdata    <= w_wdata_in;
        r_mask     <= w_mask_in;
      end
      if (r_state == S_WAIT_RSP && dmem_rsp_valid_i) r_load_data <= w_rsp_fmt;
      else if (w_timeout_hit && r_is_load)          r_load_data <= 32'h0;
    end
  end

  assign load_data_o      = r_load_data;
  assign misalign_o       = r_misalign;
  assign dmem_req_we_o    = r_we;
  assign dmem_req_addr_o  = r_req_addr;
  assign dmem_req_wdata_o = r_wdata;
  assign dmem_req_mask_o  = r_mask;

endmodule

// File: tb/tb_cl_dmem_sequencer.sv
// Directed bench for cl_dmem_sequencer: vector table of single mem ops plus hand-written
// sequences for reset, back-to-back ops, reset mid-wait and the long-wait/watchdog case.
module tb_cl_dmem_sequencer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        op_valid, is_load, is_store, is_byte;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, misalign, tmo;
  logic [31:0] load_data;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  logic        yumi, rsp_valid;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  cl_dmem_sequencer #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .op_valid_i(op_valid), .is_load_i(is_load), .is_store_i(is_store), .is_byte_i(is_byte),
    .addr_i(addr), .store_data_i(store_data),
    .stall_o(stall), .load_valid_o(load_valid), .load_data_o(load_data),
    .misalign_o(misalign), .timeout_o(tmo),
    .dmem_req_valid_o(req_valid), .dmem_req_we_o(req_we), .dmem_req_addr_o(req_addr),
    .dmem_req_wdata_o(req_wdata), .dmem_req_mask_o(req_mask),
    .dmem_req_yumi_i(yumi), .dmem_rsp_valid_i(rsp_valid), .dmem_rsp_data_i(rsp_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld, st, by;
    logic [31:0] addr, sdata;
    int          yumi_d, rsp_d;
    logic [31:0] rsp_data;
    logic        junk;
    logic        exp_mis, exp_req, exp_we;
    logic [3:0]  exp_mask;
    logic [31:0] exp_raddr, exp_wdata;
    int          exp_stall;
    logic        exp_lv;
    logic [31:0] exp_ldata;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int   stall_cnt = 0, req_cyc = 0, lv_cnt = 0, mis_cnt = 0, wcnt = 0, post = 0;
    bit   consumed = 0, accepted = 0, unstable = 0, tmo_seen = 0;
    logic [31:0] lv_data = 32'h0, s_addr = 32'h0, s_wdata = 32'h0;
    logic [3:0]  s_mask = 4'h0;
    logic        s_we = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; is_load = v.ld; is_store = v.st; is_byte = v.by;
    addr = v.addr; store_data = v.sdata;
    for (int cyc = 0; cyc < 60 && post < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (consumed) op_valid = 1'b0;
      yumi = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
      #1;
      if (req_valid) begin
        if (req_cyc == 0) begin
          s_addr = req_addr; s_wdata = req_wdata; s_mask = req_mask; s_we = req_we;
        end else if (req_addr !== s_addr || req_wdata !== s_wdata ||
                     req_mask !== s_mask || req_we !== s_we) begin
          unstable = 1;
        end
        if (req_cyc == v.yumi_d) begin
          yumi = 1'b1;
          if (v.junk) begin rsp_valid = 1'b1; rsp_data = 32'hFFFF_FFFF; end
        end
        req_cyc++;
      end else if (accepted) begin
        wcnt++;
        if (wcnt == v.rsp_d) begin rsp_valid = 1'b1; rsp_data = v.rsp_data; end
      end
      #1;
      if (stall) stall_cnt++;
      if (!consumed && !stall) consumed = 1;
      else if (consumed) post++;
      if (load_valid) begin lv_cnt++; lv_data = load_data; end
      if (misalign) mis_cnt++;
      if (tmo) tmo_seen = 1;
      if (yumi) accepted = 1;
    end
    op_valid = 1'b0; yumi = 1'b0; rsp_valid = 1'b0;
    chk($sformatf("v%0d op completed", idx), 32'(consumed), 32'd1);
    chk($sformatf("v%0d misalign pulses", idx), 32'(mis_cnt), 32'(v.exp_mis));
    chk($sformatf("v%0d request issued", idx), 32'(req_cyc > 0), 32'(v.exp_req));
    if (v.exp_req) begin
      chk($sformatf("v%0d req cycles", idx), 32'(req_cyc), 32'(v.yumi_d + 1));
      chk($sformatf("v%0d req we", idx), 32'(s_we), 32'(v.exp_we));
      chk($sformatf("v%0d req mask", idx), 32'(s_mask), 32'(v.exp_mask));
      chk($sformatf("v%0d req addr", idx), s_addr, v.exp_raddr);
      chk($sformatf("v%0d req fields stable", idx), 32'(unstable), 32'd0);
      if (v.st && !v.ld) chk($sformatf("v%0d req wdata", idx), s_wdata, v.exp_wdata);
    end
    chk($sformatf("v%0d stall cycles", idx), 32'(stall_cnt), 32'(v.exp_stall));
    chk($sformatf("v%0d load pulses", idx), 32'(lv_cnt), 32'(v.exp_lv));
    if (v.exp_lv) begin
      chk($sformatf("v%0d load data", idx), lv_data, v.exp_ldata);
      last_load = v.exp_ldata;
    end
    chk($sformatf("v%0d load data held", idx), load_data, last_load);
    chk($sformatf("v%0d timeout flag", idx), 32'(tmo_seen), 32'd0);
    $display("vec %0d: ld=%0b st=%0b by=%0b addr=0x%08h stalls=%0d reqs=%0d loads=%0d misalign=%0d",
             idx, v.ld, v.st, v.by, v.addr, stall_cnt, req_cyc, lv_cnt, mis_cnt);
  endtask

`ifdef DMEM_TIMEOUT_EN
  localparam int          LW_EXP_STALL = 9;
  localparam logic [31:0] LW_EXP_DATA  = 32'h0;
  localparam logic [31:0] LW_EXP_TMO   = 32'd1;
`else
  localparam int          LW_EXP_STALL = 22;
  localparam logic [31:0] LW_EXP_DATA  = 32'h0F0F_0F0F;
  localparam logic [31:0] LW_EXP_TMO   = 32'd0;
`endif

  initial begin
    //            ld   st   by   addr          sdata        yd rd rsp_data     junk mis  req  we   mask     raddr         wdata      stall lv  ldata
    vecs[0] = '{1'b0,1'b1,1'b0,32'h0000_0100,32'hA5A5_1234,0,0,32'h0,        1'b0,1'b0,1'b1,1'b1,4'hF,   32'h0000_0100,32'hA5A5_1234,2,1'b0,32'h0};
    vecs[1] = '{1'b1,1'b0,1'b1,32'h0000_0103,32'h0,        0,3,32'h1122_3344,1'b0,1'b0,1'b1,1'b0,4'b1000,32'h0000_0100,32'h0,        5,1'b1,32'h0000_0011};
    vecs[2] = '{1'b0,1'b1,1'b1,32'h0000_0102,32'h0000_00EE,0,0,32'h0,        1'b0,1'b0,1'b1,1'b1,4'b0100,32'h0000_0100,32'hEEEE_EEEE,2,1'b0,32'h0};
    vecs[3] = '{1'b1,1'b0,1'b0,32'h0000_0006,32'h0,        0,0,32'h0,        1'b0,1'b1,1'b0,1'b0,4'h0,   32'h0,        32'h0,        0,1'b0,32'h0};
    vecs[4] = '{1'b1,1'b0,1'b0,32'h0000_0204,32'h0,        2,1,32'hDEAD_BEEF,1'b1,1'b0,1'b1,1'b0,4'hF,   32'h0000_0204,32'h0,        5,1'b1,32'hDEAD_BEEF};
    vecs[5] = '{1'b1,1'b0,1'b1,32'h0000_0201,32'h0,        1,2,32'hCAFE_BABE,1'b0,1'b0,1'b1,1'b0,4'b0010,32'h0000_0200,32'h0,        5,1'b1,32'h0000_00BA};
    vecs[6] = '{1'b1,1'b1,1'b0,32'h0000_0300,32'h5555_5555,0,1,32'h1234_5678,1'b0,1'b0,1'b1,1'b0,4'hF,   32'h0000_0300,32'h0,        3,1'b1,32'h1234_5678};
    vecs[7] = '{1'b0,1'b1,1'b0,32'h0000_040C,32'h0BAD_F00D,5,0,32'h0,        1'b0,1'b0,1'b1,1'b1,4'hF,   32'h0000_040C,32'h0BAD_F00D,7,1'b0,32'h0};
    vecs[8] = '{1'b0,1'b1,1'b1,32'h0000_03FF,32'h1234_56C3,0,0,32'h0,        1'b0,1'b0,1'b1,1'b1,4'b1000,32'h0000_03FC,32'hC3C3_C3C3,2,1'b0,32'h0};
    vecs[9] = '{1'b0,1'b1,1'b0,32'h0000_0101,32'h0000_0001,0,0,32'h0,        1'b0,1'b1,1'b0,1'b0,4'h0,   32'h0,        32'h0,        0,1'b0,32'h0};

    n_reset = 1'b0; op_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; is_byte = 1'b0;
    addr = 32'h0; store_data = 32'h0; yumi = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    chk("reset outputs", {stall, load_valid, misalign, tmo, req_valid, req_we, req_mask}, 32'h0);
    chk("reset load_data", load_data, 32'h0);
    chk("reset req addr/wdata", req_addr | req_wdata, 32'h0);
    $display("reset: stall=%0b req_valid=%0b load_data=0x%08h", stall, req_valid, load_data);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-to-back stores with op_valid and yumi held high: DONE ignores the op, IDLE re-captures.
    begin
      logic [5:0] stall_pat = 6'h0, req_pat = 6'h0;
      @(negedge clk);
      op_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; is_byte = 1'b0;
      addr = 32'h10; store_data = 32'h77; yumi = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        stall_pat[c] = stall; req_pat[c] = req_valid;
      end
      @(negedge clk);
      op_valid = 1'b0; yumi = 1'b0;
      chk("b2b stall pattern", 32'(stall_pat), 32'b011011);
      chk("b2b req pattern", 32'(req_pat), 32'b010010);
      $display("b2b: stall=%06b req=%06b", stall_pat, req_pat);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of WAIT_RSP: op dropped, no load pulse, late response ignored.
    begin
      int lv_cnt = 0;
      logic s2;
      @(negedge clk);
      op_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; is_byte = 1'b0; addr = 32'h500;
      @(negedge clk); #1;
      yumi = req_valid;
      @(negedge clk); #1;
      yumi = 1'b0;
      s2 = stall;
      @(negedge clk);
      n_reset = 1'b0; op_valid = 1'b0;
      @(negedge clk);
      n_reset = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h9999_9999;
      #1;
      chk("rstwait stall before reset", 32'(s2), 32'd1);
      chk("rstwait outputs after reset", {stall, req_valid, load_valid}, 32'h0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        rsp_valid = 1'b0;
        if (load_valid) lv_cnt++;
      end
      chk("rstwait no load pulse", 32'(lv_cnt), 32'd0);
      chk("rstwait load_data cleared", load_data, 32'h0);
      last_load = 32'h0;
      $display("rstwait: stall_before=%0b pulses=%0d load_data=0x%08h", s2, lv_cnt, load_data);
    end

    // Load whose response arrives only after 20 wait cycles (watchdog fires first when enabled).
    begin
      int stall_cnt = 0, lv_cnt = 0, wcnt = 0, post = 0;
      bit consumed = 0, accepted = 0, tmo_seen = 0;
      logic [31:0] lv_data = 32'hFFFF_FFFF;
      @(negedge clk);
      op_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; is_byte = 1'b0; addr = 32'h600;
      for (int cyc = 0; cyc < 60 && post < 4; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (consumed) op_valid = 1'b0;
        yumi = 1'b0; rsp_valid = 1'b0;
        #1;
        if (req_valid) yumi = 1'b1;
        else if (accepted) begin
          wcnt++;
          if (wcnt == 20) begin rsp_valid = 1'b1; rsp_data = 32'h0F0F_0F0F; end
        end
        #1;
        if (stall) stall_cnt++;
        if (!consumed && !stall) consumed = 1;
        else if (consumed) post++;
        if (load_valid) begin lv_cnt++; lv_data = load_data; end
        if (tmo) tmo_seen = 1;
        if (yumi) accepted = 1;
      end
      op_valid = 1'b0; yumi = 1'b0; rsp_valid = 1'b0;
      chk("longwait completed", 32'(consumed), 32'd1);
      chk("longwait stall cycles", 32'(stall_cnt), 32'(LW_EXP_STALL));
      chk("longwait load pulses", 32'(lv_cnt), 32'd1);
      chk("longwait load data", lv_data, LW_EXP_DATA);
      chk("longwait timeout seen", 32'(tmo_seen), LW_EXP_TMO);
      chk("longwait timeout sticky", 32'(tmo), LW_EXP_TMO);
      $display("longwait: stalls=%0d pulses=%0d data=0x%08h timeout=%0b", stall_cnt, lv_cnt, lv_data, tmo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
